// File: rtl/regfile_pkg.sv
// regfile_pkg: load-type encodings, default width and load-type legality check shared by the register file.
package regfile_pkg;
   localparam int XLEN_DEF = 32;
   typedef enum logic [2:0] {
      F3_LB  = 3'd0,
      F3_LH  = 3'd1,
      F3_LW  = 3'd2,
      F3_LBU = 3'd4,
      F3_LHU = 3'd5
   } ld_type_e;
   function automatic logic is_ld_legal(input logic [2:0] f);
      return f inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
   endfunction
endpackage

// File: rtl/regfile_ld_ext.sv
// regfile_ld_ext: combinational load sign/zero extension of a raw memory word, with an illegal-type flag.
module regfile_ld_ext
   import regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] wb_data,
   input  logic [2:0]      wb_funct3,
   output logic [XLEN-1:0] ext_data,
   output logic            illegal
);
   always_comb begin
      illegal  = !is_ld_legal(wb_funct3);
      ext_data = (wb_funct3 == F3_LB)  ? {{(XLEN-8){wb_data[7]}}, wb_data[7:0]}    :
                 (wb_funct3 == F3_LH)  ? {{(XLEN-16){wb_data[15]}}, wb_data[15:0]} :
                 (wb_funct3 == F3_LBU) ? {{(XLEN-8){1'b0}}, wb_data[7:0]}          :
                 (wb_funct3 == F3_LHU) ? {{(XLEN-16){1'b0}}, wb_data[15:0]}        :
                 wb_data;
   end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with load extension and busy-bit scoreboard.
// Define REGFILE_BYPASS_EN to forward a same-edge write to the registered read ports.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int XLEN   = XLEN_DEF,
   parameter  int NREGS  = 32,
   parameter  int NRD    = 2,
   parameter  int MAX_LD = 2,
   localparam int AW     = $clog2(NREGS),
   localparam int CW     = $clog2(MAX_LD + 1)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]    rd_busy,
   input  logic              wb_valid,
   input  logic [AW-1:0]     wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              wb_is_load,
   input  logic [2:0]        wb_funct3,
   input  logic              ld_issue_valid,
   input  logic [AW-1:0]     ld_issue_addr,
   output logic              ld_issue_ready,
   output logic [CW-1:0]     ld_cnt,
   output logic              wb_err
);
   logic [XLEN-1:0]     regs_q [NREGS];
   logic [XLEN-1:0]     regs_d [NREGS];
   logic [NREGS-1:0]    busy_q, busy_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
   logic [NRD-1:0]      rd_busy_q, rd_busy_d;
   logic                err_q, err_d;
   logic [XLEN-1:0]     ext_data;
   logic                ext_ill, wb_ld, issue;

   regfile_ld_ext #(.XLEN(XLEN)) u_ext (
      .wb_data  (wb_data),
      .wb_funct3(wb_funct3),
      .ext_data (ext_data),
      .illegal  (ext_ill)
   );

   always_comb begin
      wb_ld          = wb_valid && wb_is_load;
      // A retiring load frees its count slot and its own busy bit within the same cycle
      ld_issue_ready = (cnt_q < CW'(MAX_LD) || wb_ld) &&
                       (!busy_q[ld_issue_addr] || (wb_ld && wb_addr == ld_issue_addr));
      issue          = ld_issue_valid && ld_issue_ready;
      cnt_d          = (issue && !wb_ld) ? cnt_q + CW'(1) :
                       (!issue && wb_ld && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      err_d          = (wb_ld && (cnt_q == '0 || ext_ill)) ||
                       (wb_valid && !wb_is_load && busy_q[wb_addr]);
      regs_d         = regs_q;
      if (wb_valid && wb_addr != '0 && !(wb_is_load && ext_ill))
         regs_d[wb_addr] = wb_is_load ? ext_data : wb_data;
      busy_d = busy_q;
      if (wb_ld)
         busy_d[wb_addr] = 1'b0;
      if (issue)
         busy_d[ld_issue_addr] = 1'b1;
      busy_d[0] = 1'b0;
      for (int i = 0; i < NRD; i++) begin
`ifdef REGFILE_BYPASS_EN
         rd_data_d[i*XLEN +: XLEN] = regs_d[rd_addr[i*AW +: AW]];
`else
         rd_data_d[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
`endif
         rd_busy_d[i] = busy_d[rd_addr[i*AW +: AW]];
      end
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         regs_q    <= '{default: '0};
         busy_q    <= '0;
         cnt_q     <= '0;
         rd_data_q <= '0;
         rd_busy_q <= '0;
         err_q     <= 1'b0;
      end else begin
         regs_q    <= regs_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
         rd_data_q <= rd_data_d;
         rd_busy_q <= rd_busy_d;
         err_q     <= err_d;
      end
   end

   assign rd_data = rd_data_q;
   assign rd_busy = rd_busy_q;
   assign ld_cnt  = cnt_q;
   assign wb_err  = err_q;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of reads, load extension, scoreboard, bypass and error reporting.
module tb_regfile_sb;
   logic        clk = 1'b0;
   logic        resetn;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        wb_valid, wb_is_load, ld_issue_valid, ld_issue_ready, wb_err;
   logic [4:0]  wb_addr, ld_issue_addr;
   logic [31:0] wb_data;
   logic [2:0]  wb_funct3;
   logic [1:0]  ld_cnt;
   int          n_chk = 0;
   int          n_err = 0;

   regfile_sb dut (
      .clk           (clk),
      .resetn        (resetn),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_busy       (rd_busy),
      .wb_valid      (wb_valid),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .wb_is_load    (wb_is_load),
      .wb_funct3     (wb_funct3),
      .ld_issue_valid(ld_issue_valid),
      .ld_issue_addr (ld_issue_addr),
      .ld_issue_ready(ld_issue_ready),
      .ld_cnt        (ld_cnt),
      .wb_err        (wb_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
      rd_addr = {a1, a0};
      step();
   endtask

   task automatic issue(input logic [4:0] a);
      ld_issue_valid = 1'b1;
      ld_issue_addr  = a;
      step();
      ld_issue_valid = 1'b0;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d, input logic l, input logic [2:0] f);
      wb_valid   = 1'b1;
      wb_addr    = a;
      wb_data    = d;
      wb_is_load = l;
      wb_funct3  = f;
      step();
      wb_valid   = 1'b0;
      wb_is_load = 1'b0;
   endtask

   initial begin
      logic [31:0] byp_exp;
`ifdef REGFILE_BYPASS_EN
      byp_exp = 32'h12345678;
`else
      byp_exp = 32'h0;
`endif
      resetn = 1'b1; rd_addr = '0; wb_valid = 0; wb_addr = '0; wb_data = '0;
      wb_is_load = 0; wb_funct3 = '0; ld_issue_valid = 0; ld_issue_addr = '0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b0;
      check("rst_cnt", 32'(ld_cnt), 0);
      check("rst_err", 32'(wb_err), 0);
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), 5'(31 - i));
         check("rst_rd0", rd_data[31:0], 0);
         check("rst_rd1", rd_data[63:32], 0);
         check("rst_busy", 32'(rd_busy), 0);
      end
      wb(5'd0, 32'hDEADBEEF, 1'b0, 3'd0);
      rd(5'd0, 5'd0);
      check("x0_wr", rd_data[31:0], 0);
      // load extension
      issue(5'd5);
      wb(5'd5, 32'h000000F0, 1'b1, 3'd0);
      check("lb_err", 32'(wb_err), 0);
      rd(5'd5, 5'd0);
      check("lb", rd_data[31:0], 32'hFFFFFFF0);
      check("lb_cnt", 32'(ld_cnt), 0);
      issue(5'd5); wb(5'd5, 32'h000000F0, 1'b1, 3'd4); rd(5'd5, 5'd0);
      check("lbu", rd_data[31:0], 32'h000000F0);
      issue(5'd5); wb(5'd5, 32'h00008001, 1'b1, 3'd1); rd(5'd5, 5'd0);
      check("lh", rd_data[31:0], 32'hFFFF8001);
      issue(5'd5); wb(5'd5, 32'h1234ABCD, 1'b1, 3'd5); rd(5'd5, 5'd0);
      check("lhu", rd_data[31:0], 32'h0000ABCD);
      issue(5'd5); wb(5'd5, 32'h89ABCDEF, 1'b1, 3'd2); rd(5'd5, 5'd0);
      check("lw", rd_data[31:0], 32'h89ABCDEF);
      // scoreboard on a single register
      ld_issue_valid = 1'b1; ld_issue_addr = 5'd7; #1;
      check("rdy_x7", 32'(ld_issue_ready), 1);
      step();
      #1 check("rdy_x7_busy", 32'(ld_issue_ready), 0);
      ld_issue_valid = 1'b0;
      check("cnt_x7", 32'(ld_cnt), 1);
      rd(5'd7, 5'd7);
      check("busy_x7", 32'(rd_busy), 32'h3);
      wb(5'd7, 32'h00000055, 1'b1, 3'd2);
      check("cnt_x7_ret", 32'(ld_cnt), 0);
      check("err_x7_ret", 32'(wb_err), 0);
      rd(5'd7, 5'd0);
      check("busy_x7_clr", 32'(rd_busy), 0);
      check("data_x7", rd_data[31:0], 32'h55);
      // MAX_LD limit and same-cycle retire + issue
      issue(5'd1);
      issue(5'd2);
      check("cnt_full", 32'(ld_cnt), 2);
      ld_issue_valid = 1'b1; ld_issue_addr = 5'd3; #1;
      check("rdy_full", 32'(ld_issue_ready), 0);
      wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h11; wb_is_load = 1'b1; wb_funct3 = 3'd2; #1;
      check("rdy_retire", 32'(ld_issue_ready), 1);
      step();
      ld_issue_valid = 1'b0; wb_valid = 1'b0; wb_is_load = 1'b0;
      check("cnt_swap", 32'(ld_cnt), 2);
      rd(5'd1, 5'd3);
      check("busy_swap", 32'(rd_busy), 32'h2);
      check("data_x1", rd_data[31:0], 32'h11);
      // same-edge write and read
      rd_addr = {5'd0, 5'd9};
      wb(5'd9, 32'h12345678, 1'b0, 3'd0);
      check("bypass", rd_data[31:0], byp_exp);
      check("err_x9", 32'(wb_err), 0);
      rd(5'd9, 5'd0);
      check("x9_after", rd_data[31:0], 32'h12345678);
      wb(5'd2, 32'hCAFE0000, 1'b0, 3'd0);
      check("err_busy_wr", 32'(wb_err), 1);
      rd(5'd2, 5'd0);
      check("busy_wr_data", rd_data[31:0], 32'hCAFE0000);
      check("busy_wr_kept", 32'(rd_busy), 1);
      // asynchronous reset with loads pending
      resetn = 1'b1; #1;
      check("arst_cnt", 32'(ld_cnt), 0);
      check("arst_busy", 32'(rd_busy), 0);
      step();
      resetn = 1'b0;
      rd(5'd2, 5'd3);
      check("arst_busy_rd", 32'(rd_busy), 0);
      check("arst_data", rd_data[31:0], 0);
      // error pulses
      wb(5'd4, 32'h000000AA, 1'b1, 3'd2);
      check("err_cnt0", 32'(wb_err), 1);
      check("cnt0_stay", 32'(ld_cnt), 0);
      rd(5'd4, 5'd0);
      check("err_pulse", 32'(wb_err), 0);
      check("cnt0_data", rd_data[31:0], 32'hAA);
      issue(5'd6);
      wb(5'd6, 32'h00000077, 1'b1, 3'd3);
      check("err_f3", 32'(wb_err), 1);
      check("f3_cnt", 32'(ld_cnt), 0);
      rd(5'd6, 5'd0);
      check("f3_drop", rd_data[31:0], 0);
      check("f3_busy", 32'(rd_busy), 0);
      check("f3_pulse", 32'(wb_err), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
